// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and counter-width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rx line conditioning: 2-FF synchroniser, falling-edge detect, 3-sample majority vote.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    input  logic cap0,
    input  logic cap1,
    output logic fall,
    output logic vote
);

    logic meta_q, meta_d;
    logic rxs_q, rxs_d;
    logic prev_q, prev_d;
    logic s0_q, s0_d;
    logic s1_q, s1_d;

    // Next-state for synchroniser, edge history and the two early samples.
    always_comb begin
        meta_d = rx;
        rxs_d  = meta_q;
        prev_d = rxs_q;
        s0_d   = cap0 ? rxs_q : s0_q;
        s1_d   = cap1 ? rxs_q : s1_q;
    end

    // All flops reset to the idle-high line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b1;
            rxs_q  <= 1'b1;
            prev_q <= 1'b1;
            s0_q   <= 1'b1;
            s1_q   <= 1'b1;
        end else begin
            meta_q <= meta_d;
            rxs_q  <= rxs_d;
            prev_q <= prev_d;
            s0_q   <= s0_d;
            s1_q   <= s1_d;
        end
    end

    // Third sample is the live synchronised level on the resolving tick.
    assign fall = prev_q & ~rxs_q;
    assign vote = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: FSM, tick/bit counters, shift register, error flags.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    output logic                 rx_done,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned TW = cnt_width(OVERSAMPLE);
    localparam int unsigned BW = cnt_width((DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS);

    localparam logic [TW-1:0] T_LO  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_HI  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_ONE = TW'(1);
    localparam logic [BW-1:0] B_ONE = BW'(1);
    localparam logic [BW-1:0] B_LST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] S_LST = BW'(STOP_BITS - 1);
    localparam logic          ODD   = (PARITY_ODD != 0);

    uart_state_e          state_q, state_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_done_q, rx_done_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;

    logic fall, vote, active, cap0, cap1, resolve, at_end;

    assign active  = (state_q != ST_IDLE);
    assign cap0    = tick && active && (tcnt_q == T_LO);
    assign cap1    = tick && active && (tcnt_q == T_MID);
    assign resolve = tick && (tcnt_q == T_HI);
    assign at_end  = tick && (tcnt_q == T_END);

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .cap0  (cap0),
        .cap1  (cap1),
        .fall  (fall),
        .vote  (vote)
    );

    // Frame FSM with counters, shifting, error accumulation and output load.
    always_comb begin
        state_d      = state_q;
        tcnt_d       = tcnt_q;
        bcnt_d       = bcnt_q;
        sh_d         = sh_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        rx_done_d    = 1'b0;
        rx_data_d    = rx_data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        if (tick && active) begin
            tcnt_d = tcnt_q + T_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                tcnt_d = '0;
                bcnt_d = '0;
                if (fall) begin
                    state_d = ST_START;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            ST_START: begin
                if (resolve && vote) begin
                    state_d = ST_IDLE;
                    tcnt_d  = '0;
                end else if (at_end) begin
                    state_d = ST_DATA;
                    tcnt_d  = '0;
                end
            end
            ST_DATA: begin
                if (resolve) begin
                    sh_d = {vote, sh_q[DATA_BITS-1:1]};
                end
                if (at_end) begin
                    tcnt_d = '0;
                    if (bcnt_q == B_LST) begin
                        bcnt_d  = '0;
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bcnt_d = bcnt_q + B_ONE;
                    end
                end
            end
            ST_PARITY: begin
                if (resolve && (vote != ((^sh_q) ^ ODD))) begin
                    perr_d = 1'b1;
                end
                if (at_end) begin
                    tcnt_d  = '0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // The last stop bit finishes at its vote so a following start edge is not missed.
                if (resolve) begin
                    if (!vote) begin
                        ferr_d = 1'b1;
                    end
                    if (bcnt_q == S_LST) begin
                        state_d      = ST_IDLE;
                        tcnt_d       = '0;
                        bcnt_d       = '0;
                        rx_done_d    = 1'b1;
                        rx_data_d    = sh_q;
                        parity_err_d = perr_q;
                        frame_err_d  = ferr_q | ~vote;
                    end
                end else if (at_end) begin
                    tcnt_d = '0;
                    bcnt_d = bcnt_q + B_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tcnt_d  = '0;
                bcnt_d  = '0;
            end
        endcase
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            tcnt_q       <= '0;
            bcnt_q       <= '0;
            sh_q         <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            rx_done_q    <= 1'b0;
            rx_data_q    <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tcnt_q       <= tcnt_d;
            bcnt_q       <= bcnt_d;
            sh_q         <= sh_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            rx_done_q    <= rx_done_d;
            rx_data_q    <= rx_data_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_done    = rx_done_q;
    assign rx_data    = rx_data_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = active;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 8E1, 8N2 and 5N1 instances on separate rx lines.
module tb_uart_rx_cfg;

    logic       clk;
    logic       reset;
    logic       tick;
    logic [3:0] rx_v;

    logic       done0, pe0, fe0, busy0;
    logic [7:0] d0;
    logic       done1, pe1, fe1, busy1;
    logic [7:0] d1;
    logic       done2, pe2, fe2, busy2;
    logic [7:0] d2;
    logic       done3, pe3, fe3, busy3;
    logic [4:0] d3;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt0 = 0, cnt1 = 0, cnt2 = 0, cnt3 = 0;

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx_v[0]),
        .rx_done(done0), .rx_data(d0), .parity_err(pe0), .frame_err(fe0), .busy(busy0));

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx_v[1]),
        .rx_done(done1), .rx_data(d1), .parity_err(pe1), .frame_err(fe1), .busy(busy1));

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx_v[2]),
        .rx_done(done2), .rx_data(d2), .parity_err(pe2), .frame_err(fe2), .busy(busy2));

    uart_rx_cfg #(.DATA_BITS(5), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_5n1 (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx_v[3]),
        .rx_done(done3), .rx_data(d3), .parity_err(pe3), .frame_err(fe3), .busy(busy3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rx_done pulse counters per instance.
    always @(posedge clk) begin
        if (done0) cnt0 <= cnt0 + 1;
        if (done1) cnt1 <= cnt1 + 1;
        if (done2) cnt2 <= cnt2 + 1;
        if (done3) cnt3 <= cnt3 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One tick pulse every three clocks, driven on negedges.
    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk); tick = 1'b1;
            @(negedge clk); tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send_bit(input int sel, input logic v, input int n = 16);
        rx_v[sel] = v;
        tick_n(n);
    endtask

    // A '1' bit with a single-tick low pulse near mid-bit.
    task automatic send_glitch_one(input int sel);
        rx_v[sel] = 1'b1; tick_n(8);
        rx_v[sel] = 1'b0; tick_n(1);
        rx_v[sel] = 1'b1; tick_n(7);
    endtask

    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits, input int par,
                              input int nstop, input logic last_stop, input int glitch);
        send_bit(sel, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            if (i == glitch) send_glitch_one(sel);
            else             send_bit(sel, data[i]);
        end
        if (par >= 0) send_bit(sel, par[0]);
        for (int s = 0; s < nstop; s++) send_bit(sel, (s == nstop - 1) ? last_stop : 1'b1);
    endtask

    initial begin
        logic [7:0] a5;
        reset = 1'b0;
        tick  = 1'b0;
        rx_v  = '1;
        repeat (4) @(negedge clk);

        // Reset state
        check("rst_done0", done0, 0);
        check("rst_data0", d0, 8'h00);
        check("rst_flags0", {pe0, fe0}, 0);
        check("rst_busy", {busy0, busy1, busy2, busy3}, 0);
        check("rst_data3", d3, 5'h00);

        reset = 1'b1;
        tick_n(20);

        // 8N1 0xA5, busy across the frame
        a5 = 8'hA5;
        send_bit(0, 1'b0);
        check("a5_busy_start", busy0, 1);
        for (int i = 0; i < 8; i++) send_bit(0, a5[i]);
        send_bit(0, 1'b1, 8);
        check("a5_busy_stop", busy0, 1);
        check("a5_no_done_yet", cnt0, 0);
        tick_n(8);
        check("a5_done", cnt0, 1);
        check("a5_data", d0, 8'hA5);
        check("a5_flags", {pe0, fe0}, 0);
        check("a5_idle", busy0, 0);

        // False start: low 4 ticks then high
        send_bit(0, 1'b0, 4);
        check("fs_busy", busy0, 1);
        send_bit(0, 1'b1, 9);
        check("fs_idle", busy0, 0);
        check("fs_no_done", cnt0, 1);
        check("fs_data_kept", d0, 8'hA5);
        check("fs_flags_kept", {pe0, fe0}, 0);
        tick_n(10);

        // 8E1 0x3C: bad parity then good parity
        send_frame(1, 9'h03C, 8, 1, 1, 1'b1, -1);
        check("e1_done", cnt1, 1);
        check("e1_data", d1, 8'h3C);
        check("e1_perr", pe1, 1);
        check("e1_ferr", fe1, 0);
        tick_n(10);
        send_frame(1, 9'h03C, 8, 0, 1, 1'b1, -1);
        check("e1b_done", cnt1, 2);
        check("e1b_data", d1, 8'h3C);
        check("e1b_perr", pe1, 0);

        // 8N2 0x81 with second stop low, then line stuck low
        send_frame(2, 9'h081, 8, -1, 2, 1'b0, -1);
        check("n2_done", cnt2, 1);
        check("n2_data", d2, 8'h81);
        check("n2_ferr", fe2, 1);
        check("n2_perr", pe2, 0);
        tick_n(40 * 16);
        check("n2_stuck_no_done", cnt2, 1);
        check("n2_stuck_idle", busy2, 0);
        rx_v[2] = 1'b1;
        tick_n(20);

        // Back-to-back 0x55 (glitched bit 0) and 0xAA
        send_frame(0, 9'h055, 8, -1, 1, 1'b1, 0);
        check("bb1_done", cnt0, 2);
        check("bb1_data", d0, 8'h55);
        send_frame(0, 9'h0AA, 8, -1, 1, 1'b1, -1);
        check("bb2_done", cnt0, 3);
        check("bb2_data", d0, 8'hAA);
        check("bb2_flags", {pe0, fe0}, 0);
        tick_n(10);

        // Reset during data bit 3 of 0xF0, then 0x0F
        send_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(0, 1'b0);
        send_bit(0, 1'b0, 8);
        check("r8_busy_mid", busy0, 1);
        reset   = 1'b0;
        rx_v[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("r8_rst_data", d0, 8'h00);
        reset = 1'b1;
        tick_n(40);
        check("r8_no_done", cnt0, 3);
        check("r8_idle", busy0, 0);
        send_frame(0, 9'h00F, 8, -1, 1, 1'b1, -1);
        check("r8_done", cnt0, 4);
        check("r8_data", d0, 8'h0F);

        // 5-bit: reset mid-frame, then 0x1B
        send_bit(3, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(3, 1'b0);
        send_bit(3, 1'b1, 8);
        reset   = 1'b0;
        rx_v[3] = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        tick_n(40);
        check("r5_no_done", cnt3, 0);
        check("r5_idle", busy3, 0);
        send_frame(3, 9'h01B, 5, -1, 1, 1'b1, -1);
        check("r5_done", cnt3, 1);
        check("r5_data", d3, 5'h1B);
        check("r5_flags", {pe3, fe3}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
